// File: rtl/aes_core_iter_if.sv
// Handshake bundle for the iterative AES-128 core: block request on the
// input side, registered result on the output side.
interface aes_core_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic         key_reuse;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] cyphertext;
    logic         busy;

    modport master (
        output in_valid, key_reuse, key, plaintext, out_ready,
        input  in_ready, out_valid, cyphertext, busy
    );

    modport slave (
        input  in_valid, key_reuse, key, plaintext, out_ready,
        output in_ready, out_valid, cyphertext, busy
    );
endinterface

// File: rtl/aes_core_iter.sv
// Iterative AES-128 encryption core. UNROLL rounds are evaluated per clock
// with the round key expanded on the fly; the result is registered and held
// until the consumer takes it.
//
//  state | meaning
//  ------+----------------------------------------------------------
//  IDLE  | waiting for a block, in_ready high
//  RUN   | applying UNROLL rounds per edge, ctr counts edges
//  DONE  | cyphertext valid, held until out_ready
module aes_core_iter #(
    parameter int UNROLL = 1
) (
    input logic           clk,
    input logic           reset,
    aes_core_iter_if.slave bus
);
    localparam int         NCYC     = 10 / UNROLL;
    localparam logic [3:0] CTR_LAST = 4'(NCYC - 1);

    if (UNROLL < 1 || UNROLL > 10 || (10 % UNROLL) != 0) begin : g_bad_unroll
        $error("aes_core_iter: UNROLL=%0d must divide 10", UNROLL);
    end

    // Forward S-box, entry x at bits [(255-x)*8 +: 8]
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t         fsm_q;
    logic [127:0] state_q;
    logic [127:0] rk_q;
    logic [127:0] key_q;
    logic [7:0]   rcon_q;
    logic [3:0]   ctr_q;
    logic [127:0] state_n;
    logic [127:0] rk_n;
    logic [7:0]   rcon_n;
    logic [127:0] k0;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i = row i%4, column i/4, counted from the MSB
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rc, 24'h0};
        n0 = rk[127:96] ^ t;
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    assign k0 = bus.key_reuse ? key_q : bus.key;

    // UNROLL chained rounds; MixColumns is skipped only on round 10
    always_comb begin
        state_n = state_q;
        rk_n    = rk_q;
        rcon_n  = rcon_q;
        for (int u = 0; u < UNROLL; u++) begin
            rk_n   = key_step(rk_n, rcon_n);
            rcon_n = xtime(rcon_n);
            if (ctr_q == CTR_LAST && u == UNROLL - 1)
                state_n = sub_shift(state_n) ^ rk_n;
            else
                state_n = mix_columns(sub_shift(state_n)) ^ rk_n;
        end
    end

    // Sequencing FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q          <= IDLE;
            bus.in_ready   <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.cyphertext <= '0;
            key_q          <= '0;
            rk_q           <= '0;
            state_q        <= '0;
            ctr_q          <= '0;
            rcon_q         <= 8'h01;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        key_q        <= k0;
                        rk_q         <= k0;
                        state_q      <= bus.plaintext ^ k0;
                        rcon_q       <= 8'h01;
                        ctr_q        <= '0;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        fsm_q        <= RUN;
                    end
                end
                RUN: begin
                    state_q <= state_n;
                    rk_q    <= rk_n;
                    rcon_q  <= rcon_n;
                    ctr_q   <= ctr_q + 4'd1;
                    if (ctr_q == CTR_LAST) begin
                        bus.cyphertext <= state_n;
                        bus.out_valid  <= 1'b1;
                        fsm_q          <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        fsm_q         <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_core_iter.sv
// Bench for aes_core_iter: four instances (UNROLL 1, 2, 5, 10) share one
// stimulus stream; results are checked against a byte-level AES model whose
// S-box is derived from GF(2^8) inversion.
module tb_aes_core_iter;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         key_reuse = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] key = '0;
    logic [127:0] plaintext = '0;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb [256];
    logic [127:0] model_key = '0;
    int           ncyc [4] = '{10, 5, 2, 1};

    logic         ov [4];
    logic         ir [4];
    logic         bz [4];
    logic [127:0] ct [4];

    always #5 clk = ~clk;

    aes_core_iter_if b1 ();
    aes_core_iter_if b2 ();
    aes_core_iter_if b5 ();
    aes_core_iter_if b10 ();

    assign b1.in_valid = in_valid;   assign b1.key_reuse = key_reuse;   assign b1.key = key;
    assign b1.plaintext = plaintext; assign b1.out_ready = out_ready;
    assign b2.in_valid = in_valid;   assign b2.key_reuse = key_reuse;   assign b2.key = key;
    assign b2.plaintext = plaintext; assign b2.out_ready = out_ready;
    assign b5.in_valid = in_valid;   assign b5.key_reuse = key_reuse;   assign b5.key = key;
    assign b5.plaintext = plaintext; assign b5.out_ready = out_ready;
    assign b10.in_valid = in_valid;  assign b10.key_reuse = key_reuse;  assign b10.key = key;
    assign b10.plaintext = plaintext; assign b10.out_ready = out_ready;

    assign ov[0] = b1.out_valid;  assign ir[0] = b1.in_ready;  assign bz[0] = b1.busy;  assign ct[0] = b1.cyphertext;
    assign ov[1] = b2.out_valid;  assign ir[1] = b2.in_ready;  assign bz[1] = b2.busy;  assign ct[1] = b2.cyphertext;
    assign ov[2] = b5.out_valid;  assign ir[2] = b5.in_ready;  assign bz[2] = b5.busy;  assign ct[2] = b5.cyphertext;
    assign ov[3] = b10.out_valid; assign ir[3] = b10.in_ready; assign bz[3] = b10.busy; assign ct[3] = b10.cyphertext;

    aes_core_iter #(.UNROLL(1))  u1  (.clk(clk), .reset(reset), .bus(b1.slave));
    aes_core_iter #(.UNROLL(2))  u2  (.clk(clk), .reset(reset), .bus(b2.slave));
    aes_core_iter #(.UNROLL(5))  u5  (.clk(clk), .reset(reset), .bus(b5.slave));
    aes_core_iter #(.UNROLL(10)) u10 (.clk(clk), .reset(reset), .bus(b10.slave));

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   coef [4];
        logic [7:0]   rc;
        logic [127:0] res;
        coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
            for (int i = 0; i < 16; i++) begin
                if (rnd < 10) begin
                    s[i] = 8'h00;
                    for (int j = 0; j < 4; j++)
                        s[i] ^= gmul(coef[(j - (i%4) + 4) % 4], t[4*(i/4) + j]);
                end else begin
                    s[i] = t[i];
                end
                s[i] ^= w[4*rnd + i/4][31-8*(i%4) -: 8];
            end
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_key = '0;
    endtask

    task automatic issue(input logic [127:0] k, input logic [127:0] p, input logic reuse,
                         output logic [127:0] exp);
        logic [127:0] k0;
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = ir[0] && ir[1] && ir[2] && ir[3];
        end
        if (!ok) begin
            errors++;
            $display("FAIL issue_wait: in_ready not high on all cores within 40 cycles");
        end
        key = k;
        plaintext = p;
        key_reuse = reuse;
        in_valid = 1'b1;
        @(posedge clk);
        k0 = reuse ? model_key : k;
        model_key = k0;
        exp = aes_ref(k0, p);
        @(negedge clk);
        in_valid = 1'b0;
        key = rand128();
        plaintext = rand128();
        key_reuse = 1'($urandom);
    endtask

    task automatic collect(input logic [127:0] exp, input string name);
        int lat [4];
        for (int i = 0; i < 4; i++) lat[i] = -1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (ov[i] && lat[i] < 0) begin
                    lat[i] = n;
                    checks++;
                    if (ct[i] !== exp) begin
                        errors++;
                        $display("FAIL %s_ct[u%0d]: got %h expected %h", name, 10 / ncyc[i], ct[i], exp);
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lat[i] !== ncyc[i]) begin
                errors++;
                $display("FAIL %s_latency[u%0d]: got %0d expected %0d", name, 10 / ncyc[i], lat[i], ncyc[i]);
            end
            checks++;
            if (ov[i] !== 1'b0 || ir[i] !== 1'b1 || ct[i] !== exp) begin
                errors++;
                $display("FAIL %s_after[u%0d]: ov=%b ir=%b ct=%h expected ov=0 ir=1 ct=%h",
                         name, 10 / ncyc[i], ov[i], ir[i], ct[i], exp);
            end
        end
    endtask

    task automatic check_idle_reset(input string name);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ir[i] !== 1'b1 || ov[i] !== 1'b0 || bz[i] !== 1'b0 || ct[i] !== '0) begin
                errors++;
                $display("FAIL %s[u%0d]: ir=%b ov=%b busy=%b ct=%h expected 1 0 0 0",
                         name, 10 / ncyc[i], ir[i], ov[i], bz[i], ct[i]);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        check_idle_reset("reset_state");
    endtask

    task automatic test_fips_vectors();
        logic [127:0] e;
        issue(KEY_B, PT_B, 1'b0, e);
        collect(CT_B, "app_b");
        issue(KEY_C, PT_C, 1'b0, e);
        collect(CT_C, "app_c1");
    endtask

    task automatic test_key_reuse();
        logic [127:0] e;
        issue(KEY_B, PT_B, 1'b0, e);
        collect(CT_B, "reuse_first");
        issue({128{1'b1}}, PT_B, 1'b1, e);
        collect(CT_B, "reuse_second");
    endtask

    task automatic test_back_pressure();
        logic [127:0] e;
        logic [127:0] k_new;
        logic [127:0] p_new;
        out_ready = 1'b0;
        issue(KEY_C, PT_C, 1'b0, e);
        repeat (12) @(negedge clk);
        k_new = rand128();
        p_new = rand128();
        key = k_new;
        plaintext = p_new;
        key_reuse = 1'b0;
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ct[i] !== CT_C || ov[i] !== 1'b1 || ir[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold[u%0d] cyc %0d: ct=%h ov=%b ir=%b expected ct=%h ov=1 ir=0",
                             10 / ncyc[i], n, ct[i], ov[i], ir[i], CT_C);
                end
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ov[i] !== 1'b0 || ir[i] !== 1'b1 || ct[i] !== CT_C) begin
                errors++;
                $display("FAIL bp_release[u%0d]: ov=%b ir=%b ct=%h expected ov=0 ir=1 ct=%h",
                         10 / ncyc[i], ov[i], ir[i], ct[i], CT_C);
            end
        end
        @(posedge clk);
        model_key = k_new;
        e = aes_ref(k_new, p_new);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bz[i] !== 1'b1 || ir[i] !== 1'b0) begin
                errors++;
                $display("FAIL bp_accept[u%0d]: busy=%b ir=%b expected busy=1 ir=0", 10 / ncyc[i], bz[i], ir[i]);
            end
        end
        collect(e, "bp_next");
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] e;
        issue(KEY_B, PT_B, 1'b0, e);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_key = '0;
        check_idle_reset("mid_run_reset");
        issue(KEY_C, PT_C, 1'b0, e);
        collect(CT_C, "after_abort");
    endtask

    task automatic test_reuse_after_reset();
        logic [127:0] e;
        apply_reset();
        issue({128{1'b1}}, 128'h0, 1'b1, e);
        collect(CT_Z, "reuse_zero_key");
    endtask

    task automatic test_random();
        logic [127:0] e;
        for (int n = 0; n < 10; n++) begin
            issue(rand128(), rand128(), ($urandom_range(3) == 0), e);
            collect(e, "random");
        end
    endtask

    initial begin
        init_sbox();
        test_reset();
        test_fips_vectors();
        test_key_reuse();
        test_back_pressure();
        test_reset_mid_run();
        test_reuse_after_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
